// File: rtl/hw_header_checksum_check_with_pseudoheader.sv
// RX-side TCP/UDP checksum verifier: ones'-complement sum over the segment plus the IPv4 pseudo header.
// Optional UDP_ZERO_CSUM_BYPASS_EN: a zero UDP checksum field forces chk_ok.
module hw_header_checksum_check_with_pseudoheader #(
    parameter int CNT_W       = 16,
    parameter int FOLD_CYCLES = 2
) (
    input  logic        pe_clk,
    input  logic        pe_rstn,
    input  logic        pe_logic_clr,
    input  logic        process_start,
    input  logic        process_data_valid,
    input  logic        process_finish,
    input  logic [7:0]  data_in,
    input  logic [31:0] src_ip,
    input  logic [31:0] des_ip,
    input  logic [7:0]  payload_type,
    input  logic [15:0] length,
    output logic [15:0] chk_sum_out,
    output logic        chk_ok,
    output logic        chk_len_err,
    output logic        chk_done
);

    // state  | meaning
    // IDLE   | waiting for process_start
    // ACCUM  | summing segment bytes as 16-bit words
    // PAD    | add the dangling high octet of an odd-length segment
    // PSEUDO | add the IPv4 pseudo header
    // FOLD   | fold carries back into the low half-word
    // DONE   | results registered and held
    typedef enum logic [2:0] {IDLE, ACCUM, PAD, PSEUDO, FOLD, DONE} state_t;

    state_t            state, state_next;
    logic [31:0]       acc;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        hi;
    logic [1:0]        fold_cnt;
    logic [31:0]       pseudo_sum;
    logic              bypass;

    assign pseudo_sum = 32'(src_ip[31:16]) + 32'(src_ip[15:0])
                      + 32'(des_ip[31:16]) + 32'(des_ip[15:0])
                      + 32'(payload_type)  + 32'(length);

    always_ff @(posedge pe_clk or negedge pe_rstn) begin
        if (!pe_rstn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (pe_logic_clr) begin
            state_next = IDLE;
        end else if (process_start) begin
            state_next = ACCUM;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                ACCUM:   if (process_finish) state_next = PAD;
                PAD:     state_next = PSEUDO;
                PSEUDO:  state_next = FOLD;
                FOLD:    if (fold_cnt == 2'd0) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge pe_clk or negedge pe_rstn) begin
        if (!pe_rstn) begin
            acc         <= '0;
            cnt         <= '0;
            hi          <= '0;
            fold_cnt    <= '0;
            chk_sum_out <= '0;
            chk_ok      <= 1'b0;
            chk_len_err <= 1'b0;
            chk_done    <= 1'b0;
        end else if (pe_logic_clr || process_start) begin
            acc         <= '0;
            cnt         <= '0;
            hi          <= '0;
            fold_cnt    <= '0;
            chk_sum_out <= '0;
            chk_ok      <= 1'b0;
            chk_len_err <= 1'b0;
            chk_done    <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (process_data_valid) begin
                        if (!cnt[0]) hi  <= data_in;
                        else         acc <= acc + {16'h0000, hi, data_in};
                        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
                    end
                end
                PAD: begin
                    if (cnt[0]) acc <= acc + {16'h0000, hi, 8'h00};
                end
                PSEUDO: begin
                    acc      <= acc + pseudo_sum;
                    fold_cnt <= 2'(FOLD_CYCLES - 1);
                end
                FOLD: begin
                    acc <= {16'h0000, acc[31:16]} + {16'h0000, acc[15:0]};
                    if (fold_cnt != 2'd0) fold_cnt <= fold_cnt - 2'd1;
                end
                DONE: begin
                    chk_sum_out <= acc[15:0];
                    chk_ok      <= (acc[15:0] == 16'hFFFF) || bypass;
                    chk_len_err <= (cnt != CNT_W'(length));
                    chk_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef UDP_ZERO_CSUM_BYPASS_EN
    logic [15:0] udp_field;

    // Bytes 6..7 of a UDP header hold its checksum; zero means "not computed".
    always_ff @(posedge pe_clk or negedge pe_rstn) begin
        if (!pe_rstn) begin
            udp_field <= '0;
        end else if (pe_logic_clr || process_start) begin
            udp_field <= '0;
        end else if (state == ACCUM && process_data_valid) begin
            if (cnt == CNT_W'(6)) udp_field[15:8] <= data_in;
            if (cnt == CNT_W'(7)) udp_field[7:0]  <= data_in;
        end
    end

    assign bypass = (payload_type == 8'd17) && (udp_field == 16'h0000);
`else
    assign bypass = 1'b0;
`endif

endmodule
